// File: rtl/fpu_op_scheduler.sv
// Round-robin scheduler sharing one combinational FPU between REQ_COUNT requesters.
// Define FPU_OP_SCHEDULER_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration.
module fpu_op_scheduler #(
    parameter int REQ_COUNT = 4,
    parameter int ID_W      = 2,
    parameter int WAIT_ADD  = 1,
    parameter int WAIT_MUL  = 1,
    parameter int WAIT_DIV  = 4,
    parameter int WAIT_CVT  = 1
) (
    input  logic                    MCLK,
    input  logic                    RST,
    input  logic [REQ_COUNT-1:0]    REQ_VALID,
    output logic [REQ_COUNT-1:0]    REQ_READY,
    input  logic [3*REQ_COUNT-1:0]  REQ_OP,
    input  logic [32*REQ_COUNT-1:0] REQ_A,
    input  logic [32*REQ_COUNT-1:0] REQ_B,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [ID_W-1:0]         RSP_ID,
    output logic [31:0]             RSP_DATA,
    output logic [2:0]              FPU_OP,
    output logic [31:0]             FPU_A,
    output logic [31:0]             FPU_B,
    input  logic [31:0]             FPU_O,
    output logic                    BUSY
);

    localparam int CNT_W = 8;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_DIV = 3'd2;
    localparam logic [2:0] OP_F2I = 3'd3;
    localparam logic [2:0] OP_I2F = 3'd4;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   win;
    logic              found;
    logic [ID_W-1:0]   id_q;
    logic [2:0]        op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       data_q;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        win_op;
    logic              win_legal;
    logic              win_cvt;

    logic [2:0]  op_arr [REQ_COUNT];
    logic [31:0] a_arr  [REQ_COUNT];
    logic [31:0] b_arr  [REQ_COUNT];

    for (genvar g = 0; g < REQ_COUNT; g++) begin : g_unpack
        assign op_arr[g] = REQ_OP[3*g +: 3];
        assign a_arr[g]  = REQ_A[32*g +: 32];
        assign b_arr[g]  = REQ_B[32*g +: 32];
    end

`ifdef FPU_OP_SCHEDULER_FIXED_PRIORITY_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (!found && REQ_VALID[ID_W'(i)]) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] ptr;

    // Search starts at the pointer and wraps, so the last-served requester goes to the back.
    always_comb begin
        logic [ID_W-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            idx = ID_W'((int'(ptr) + i) % REQ_COUNT);
            if (!found && REQ_VALID[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            ptr <= '0;
        end else if (state == RESP && RSP_READY) begin
            ptr <= (id_q == ID_W'(REQ_COUNT - 1)) ? '0 : id_q + 1'b1;
        end
    end
`endif

    assign win_op    = op_arr[win];
    assign win_legal = (win_op <= OP_I2F);
    assign win_cvt   = (win_op == OP_F2I) || (win_op == OP_I2F);

    function automatic logic [CNT_W-1:0] wait_load(input logic [2:0] op);
        case (op)
            OP_ADD:  return CNT_W'(WAIT_ADD - 1);
            OP_MUL:  return CNT_W'(WAIT_MUL - 1);
            OP_DIV:  return CNT_W'(WAIT_DIV - 1);
            default: return CNT_W'(WAIT_CVT - 1);
        endcase
    endfunction

    always_ff @(posedge MCLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (found) next_state = win_legal ? EXEC : RESP;
            EXEC: if (cnt == '0) next_state = RESP;
            RESP: if (RSP_READY) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FPU operand registers only change on a legal accept, so the datapath bus never toggles otherwise.
    always_ff @(posedge MCLK) begin
        if (RST) begin
            id_q   <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        id_q <= win;
                        if (win_legal) begin
                            op_q <= win_op;
                            a_q  <= a_arr[win];
                            b_q  <= win_cvt ? 32'd0 : b_arr[win];
                            cnt  <= wait_load(win_op);
                        end else begin
                            data_q <= QNAN;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        data_q <= FPU_O;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        REQ_READY = '0;
        if (state == IDLE && found) begin
            REQ_READY[win] = 1'b1;
        end
        RSP_VALID = (state == RESP);
        BUSY      = (state != IDLE);
    end

    assign RSP_ID   = id_q;
    assign RSP_DATA = data_q;
    assign FPU_OP   = op_q;
    assign FPU_A    = a_q;
    assign FPU_B    = b_q;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Directed bench for fpu_op_scheduler with a stub FPU datapath.
module tb_fpu_op_scheduler;

    logic        MCLK;
    logic        RST;
    logic [3:0]  REQ_VALID;
    logic [3:0]  REQ_READY;
    logic [11:0] REQ_OP;
    logic [127:0] REQ_A;
    logic [127:0] REQ_B;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [1:0]  RSP_ID;
    logic [31:0] RSP_DATA;
    logic [2:0]  FPU_OP;
    logic [31:0] FPU_A;
    logic [31:0] FPU_B;
    logic [31:0] FPU_O;
    logic        BUSY;

    int vectors_applied = 0;
    int miscompares     = 0;

    fpu_op_scheduler dut (
        .MCLK(MCLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP), .REQ_A(REQ_A), .REQ_B(REQ_B),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
        .FPU_OP(FPU_OP), .FPU_A(FPU_A), .FPU_B(FPU_B), .FPU_O(FPU_O),
        .BUSY(BUSY)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // Stub datapath: real float results for the two known vectors, integer a+b+op otherwise.
    function automatic logic [31:0] fpu_stub(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 3'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 3'd2 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        return a + b + {29'd0, op};
    endfunction

    assign FPU_O = fpu_stub(FPU_OP, FPU_A, FPU_B);

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        REQ_OP[idx*3 +: 3]  = op;
        REQ_A[idx*32 +: 32] = a;
        REQ_B[idx*32 +: 32] = b;
        REQ_VALID[idx]      = 1'b1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   exp_id;
        logic seen;

        RST       = 1'b1;
        RSP_READY = 1'b1;
        REQ_VALID = '0;
        REQ_OP    = '0;
        REQ_A     = '0;
        REQ_B     = '0;
        repeat (3) tick();
        RST = 1'b0;
        checkOutput("rst_busy",   {31'd0, BUSY}, 32'd0);
        checkOutput("rst_rspv",   {31'd0, RSP_VALID}, 32'd0);
        checkOutput("rst_data",   RSP_DATA, 32'd0);
        checkOutput("rst_fpu_a",  FPU_A, 32'd0);
        checkOutput("rst_ready",  {28'd0, REQ_READY}, 32'd0);

        // ADD on requester 0
        applyStimulus(0, 3'd0, 32'h3F800000, 32'h40000000);
        checkOutput("add_ready", {28'd0, REQ_READY}, 32'h1);
        tick();
        REQ_VALID[0] = 1'b0;
        checkOutput("add_exec_rspv", {31'd0, RSP_VALID}, 32'd0);
        checkOutput("add_exec_busy", {31'd0, BUSY}, 32'd1);
        checkOutput("add_fpu_a", FPU_A, 32'h3F800000);
        tick();
        checkOutput("add_rspv", {31'd0, RSP_VALID}, 32'd1);
        checkOutput("add_data", RSP_DATA, 32'h40400000);
        checkOutput("add_id", {30'd0, RSP_ID}, 32'd0);
        tick();
        checkOutput("add_idle", {31'd0, BUSY}, 32'd0);

        // DIV on requester 2 with a 4-cycle settle window
        applyStimulus(2, 3'd2, 32'h40C00000, 32'h40000000);
        checkOutput("div_ready", {28'd0, REQ_READY}, 32'h4);
        tick();
        REQ_VALID[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("div_a_c%0d", k + 1), FPU_A, 32'h40C00000);
            checkOutput($sformatf("div_b_c%0d", k + 1), FPU_B, 32'h40000000);
            checkOutput($sformatf("div_rspv_c%0d", k + 1), {31'd0, RSP_VALID}, 32'd0);
            tick();
        end
        checkOutput("div_rspv", {31'd0, RSP_VALID}, 32'd1);
        checkOutput("div_data", RSP_DATA, 32'h40400000);
        checkOutput("div_id", {30'd0, RSP_ID}, 32'd2);
        tick();

        // Fresh pointer, then all four requesters continuously valid
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(i, 3'd0, 32'h100 * (i + 1), 32'd0);
        for (int k = 0; k < 5; k++) begin
`ifdef FPU_OP_SCHEDULER_FIXED_PRIORITY_EN
            exp_id = 0;
`else
            exp_id = k % 4;
`endif
            checkOutput($sformatf("rr_grant%0d", k), {28'd0, REQ_READY}, 32'd1 << exp_id);
            tick();
            checkOutput($sformatf("rr_exec_ready%0d", k), {28'd0, REQ_READY}, 32'd0);
            tick();
            checkOutput($sformatf("rr_id%0d", k), {30'd0, RSP_ID}, exp_id);
            checkOutput($sformatf("rr_data%0d", k), RSP_DATA, 32'h100 * (exp_id + 1));
            tick();
        end
        REQ_VALID = '0;
        #1;

        // Response backpressure with another requester waiting
        RSP_READY = 1'b0;
        applyStimulus(1, 3'd0, 32'h55, 32'h11);
        applyStimulus(3, 3'd0, 32'h30, 32'h1);
        checkOutput("bp_grant1", {28'd0, REQ_READY}, 32'h2);
        tick();
        REQ_VALID[1] = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("bp_rspv%0d", k), {31'd0, RSP_VALID}, 32'd1);
            checkOutput($sformatf("bp_data%0d", k), RSP_DATA, 32'h66);
            checkOutput($sformatf("bp_ready%0d", k), {28'd0, REQ_READY}, 32'd0);
            tick();
        end
        RSP_READY = 1'b1;
        checkOutput("bp_rspv_hs", {31'd0, RSP_VALID}, 32'd1);
        checkOutput("bp_data_hs", RSP_DATA, 32'h66);
        tick();
        checkOutput("bp_grant3", {28'd0, REQ_READY}, 32'h8);
        tick();
        REQ_VALID[3] = 1'b0;
        tick();
        checkOutput("bp_id3", {30'd0, RSP_ID}, 32'd3);
        checkOutput("bp_data3", RSP_DATA, 32'h31);
        tick();

        // Illegal opcode short-circuits to a quiet NaN response
        applyStimulus(1, 3'd6, 32'h12345678, 32'h9ABCDEF0);
        checkOutput("ill_ready", {28'd0, REQ_READY}, 32'h2);
        tick();
        REQ_VALID[1] = 1'b0;
        checkOutput("ill_rspv", {31'd0, RSP_VALID}, 32'd1);
        checkOutput("ill_data", RSP_DATA, 32'h7FC00000);
        checkOutput("ill_id", {30'd0, RSP_ID}, 32'd1);
        checkOutput("ill_fpu_a_hold", FPU_A, 32'h30);
        tick();

        // F2I drops operand B
        applyStimulus(0, 3'd3, 32'h40490FDB, 32'hDEADBEEF);
        checkOutput("f2i_ready", {28'd0, REQ_READY}, 32'h1);
        tick();
        REQ_VALID[0] = 1'b0;
        checkOutput("f2i_op", {29'd0, FPU_OP}, 32'd3);
        checkOutput("f2i_b", FPU_B, 32'd0);
        tick();
        checkOutput("f2i_data", RSP_DATA, 32'h40490FDE);
        checkOutput("f2i_id", {30'd0, RSP_ID}, 32'd0);
        tick();

        // Reset in the middle of a DIV
        applyStimulus(2, 3'd2, 32'h40C00000, 32'h40000000);
        tick();
        REQ_VALID[2] = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("abort_busy", {31'd0, BUSY}, 32'd0);
        checkOutput("abort_rspv", {31'd0, RSP_VALID}, 32'd0);
        checkOutput("abort_data", RSP_DATA, 32'd0);
        checkOutput("abort_fpu_op", {29'd0, FPU_OP}, 32'd0);
        checkOutput("abort_fpu_a", FPU_A, 32'd0);
        checkOutput("abort_fpu_b", FPU_B, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (RSP_VALID) seen = 1'b1;
        end
        checkOutput("abort_no_rsp", {31'd0, seen}, 32'd0);

        // Valid withdrawn before a clock edge latches nothing
        applyStimulus(1, 3'd0, 32'h1, 32'h2);
        REQ_VALID[1] = 1'b0;
        tick();
        checkOutput("withdraw_busy", {31'd0, BUSY}, 32'd0);

        // Requesters 0 and 3 contend continuously
        applyStimulus(0, 3'd0, 32'h10, 32'd0);
        applyStimulus(3, 3'd0, 32'h40, 32'd0);
        for (int k = 0; k < 4; k++) begin
`ifdef FPU_OP_SCHEDULER_FIXED_PRIORITY_EN
            exp_id = 0;
`else
            exp_id = (k % 2 == 0) ? 0 : 3;
`endif
            checkOutput($sformatf("pair_grant%0d", k), {28'd0, REQ_READY}, 32'd1 << exp_id);
            tick();
            tick();
            checkOutput($sformatf("pair_id%0d", k), {30'd0, RSP_ID}, exp_id);
            tick();
        end
        REQ_VALID = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_op_scheduler.md
Name: fpu_op_scheduler

Overview:
- Shares one combinational FPU datapath (add, mul, div, float-to-int, int-to-float) between REQ_COUNT requesters.
- Arbitrates round-robin between requesters and drives the shared FPU operand/opcode bus.
- Holds the operands stable for a per-op multicycle settle window, then captures the result.
- Returns the result tagged with the requester ID over a valid/ready response channel.

Parameters:
- REQ_COUNT, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(REQ_COUNT).
- WAIT_ADD, 1, settle cycles for ADD (>=1).
- WAIT_MUL, 1, settle cycles for MUL (>=1).
- WAIT_DIV, 4, settle cycles for DIV (>=1).
- WAIT_CVT, 1, settle cycles for F2I and I2F (>=1).

Ports:
- MCLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ_VALID  in  REQ_COUNT  per-requester request valid.
- REQ_READY  out  REQ_COUNT  per-requester accept; at most one bit high.
- REQ_OP  in  3*REQ_COUNT  opcode per requester: 0 ADD, 1 MUL, 2 DIV, 3 F2I, 4 I2F, 5-7 illegal.
- REQ_A  in  32*REQ_COUNT  operand A per requester.
- REQ_B  in  32*REQ_COUNT  operand B per requester.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response accept.
- RSP_ID  out  ID_W  index of the requester that issued the request.
- RSP_DATA  out  32  result.
- FPU_OP  out  3  opcode to the shared datapath.
- FPU_A  out  32  operand A to the datapath.
- FPU_B  out  32  operand B to the datapath.
- FPU_O  in  32  datapath result (combinational).
- BUSY  out  1  high when state is not IDLE.

Behaviour:
- Reset (RST high at a clock edge):
  - state IDLE, RR pointer 0.
  - All outputs 0: REQ_READY, RSP_VALID, RSP_ID, RSP_DATA, FPU_OP, FPU_A, FPU_B, BUSY.
  - Reset mid-operation aborts the operation; no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any REQ_VALID is high, the winner is the first valid index at or after the pointer, wrapping.
  - REQ_READY[winner] is driven combinationally in the same cycle.
  - At the edge: latch op, A, B and the winner ID. For F2I and I2F, B is latched as 0.
  - Load counter = WAIT_x - 1 and go to EXEC.
  - Illegal op: go directly to RESP with RSP_DATA = 32'h7FC0_0000 (quiet NaN).
- EXEC:
  - FPU_OP, FPU_A, FPU_B are driven from the latched registers and stay constant.
  - Counter decrements each cycle.
  - On the cycle the counter reaches 0: capture FPU_O into RSP_DATA, go to RESP.
- RESP:
  - RSP_VALID = 1; RSP_ID and RSP_DATA held stable.
  - On RSP_VALID && RSP_READY: go to IDLE and set pointer = (ID + 1) mod REQ_COUNT.
- Latency:
  - Accept at cycle 0; RSP_VALID first high at cycle WAIT_x + 1.
  - Illegal op: RSP_VALID at cycle 1.
  - Minimum issue interval is WAIT_x + 2 cycles.
- REQ_READY is never asserted outside IDLE. Requesters hold REQ_VALID and payload until accepted.
- FPU_* outputs hold their last values in IDLE and RESP; they do not toggle without a new accept.
- RSP_READY high while RSP_VALID is low has no effect.
- REQ_VALID deasserted before READY (protocol violation): no request is latched.

Optional Feature:
- Macro: FPU_OP_SCHEDULER_FIXED_PRIORITY_EN.
- Defined: fixed priority; the lowest valid index always wins and the pointer is not updated. Starvation is permitted.
- Undefined: round-robin as described above.

Test Plan:
- Req0 ADD A=0x3F800000, B=0x40000000, RSP_READY=1 → REQ_READY[0] at cycle 0; RSP_VALID at cycle 2 with RSP_DATA=0x40400000, RSP_ID=0.
- Req2 DIV A=0x40C00000, B=0x40000000 → FPU_A/FPU_B stable for 4 EXEC cycles; RSP_VALID at cycle 5, RSP_DATA=0x40400000, RSP_ID=2.
- All 4 requesters continuously valid with ADD → grant order 0,1,2,3,0; responses carry matching RSP_IDs.
- RSP_READY held low 3 cycles in RESP → RSP_VALID and RSP_DATA held, REQ_READY stays 0; handshake on cycle 4, then next grant.
- Req1 op=6 → RSP_VALID at cycle 1 with RSP_DATA=0x7FC00000, RSP_ID=1. RST pulse during a DIV EXEC → next cycle IDLE, all outputs 0, no response.
- With FIXED_PRIORITY_EN, req0 and req3 continuously valid → req3 is never granted; without the macro, grants alternate 0,3.
